// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester arbiter (instruction fetch port I, data port D)
//               in front of a single shared word-addressed RAM with a
//               combinational read path. One transaction is in flight at a
//               time: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (ack).
//               Ties are broken round-robin via a last-grant flag, or in
//               favour of D when ARB_DATA_PRIORITY_EN is defined.
// Build macro : ARB_DATA_PRIORITY_EN  (defined: D always wins a tie;
//                                      undefined: round-robin, I wins first)
// Parameters  : WAIT_CYCLES  extra ACCESS cycles before sampling RAM (0..15)
// Ports       : clk, reset          clock / synchronous active-high reset
//               i_req, i_addr       fetch request (held until i_ack)
//               i_ack, i_rdata      fetch completion pulse / fetched word
//               d_req, d_we, d_addr, d_wdata, d_byteen
//                                   data request (held until d_ack)
//               d_ack, d_rdata      data completion pulse / read word
//               mem_address, mem_read, mem_write, mem_writedata,
//               mem_byteenable      shared RAM command bus
//               mem_readdata        combinational RAM read data
//               busy                high whenever the FSM is not IDLE
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  // shared RAM
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  // status
  output logic        busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  count;
  logic [3:0]  count_next;

  // Transaction fields captured at grant time. The RAM bus is driven only
  // from these, so requesters may change or drop their inputs once granted.
  logic        grant_d;
  logic        grant_d_next;
  logic [31:0] lat_addr;
  logic [31:0] lat_addr_next;
  logic        lat_we;
  logic        lat_we_next;
  logic [31:0] lat_wdata;
  logic [31:0] lat_wdata_next;
  logic [3:0]  lat_byteen;
  logic [3:0]  lat_byteen_next;

  logic        i_ack_next;
  logic        d_ack_next;
  logic [31:0] i_rdata_next;
  logic [31:0] d_rdata_next;

  // Winner for the current IDLE cycle (1 = data port).
  logic        pick_d;

  // --------------------------------------------------------------------------
  // Tie-break policy
  // --------------------------------------------------------------------------
`ifdef ARB_DATA_PRIORITY_EN
  // Data port has strict priority; no grant history is needed.
  assign pick_d = d_req;
`else
  // last_grant_d remembers who won the previous grant. Reset value 1 makes
  // the instruction port win the very first tie.
  logic last_grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b1;
    end else if ((state == ST_IDLE) && (i_req || d_req)) begin
      last_grant_d <= pick_d;
    end
  end

  // D wins when it is the only requester, or on a tie when I won last time.
  assign pick_d = d_req && (!i_req || !last_grant_d);
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      grant_d    <= 1'b0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      lat_byteen <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      grant_d    <= grant_d_next;
      lat_addr   <= lat_addr_next;
      lat_we     <= lat_we_next;
      lat_wdata  <= lat_wdata_next;
      lat_byteen <= lat_byteen_next;
      i_ack      <= i_ack_next;
      d_ack      <= d_ack_next;
      i_rdata    <= i_rdata_next;
      d_rdata    <= d_rdata_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    count_next      = count;
    grant_d_next    = grant_d;
    lat_addr_next   = lat_addr;
    lat_we_next     = lat_we;
    lat_wdata_next  = lat_wdata;
    lat_byteen_next = lat_byteen;
    i_rdata_next    = i_rdata;
    d_rdata_next    = d_rdata;
    // Acks are single-cycle pulses: they default low every cycle and are set
    // only on the ACCESS -> RESP transition, so they are high exactly in RESP.
    i_ack_next      = 1'b0;
    d_ack_next      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant_d_next = pick_d;
          if (pick_d) begin
            lat_addr_next   = d_addr;
            lat_we_next     = d_we;
            lat_wdata_next  = d_wdata;
            lat_byteen_next = d_byteen;
          end else begin
            // Fetches are always full-word reads.
            lat_addr_next   = i_addr;
            lat_we_next     = 1'b0;
            lat_wdata_next  = '0;
            lat_byteen_next = 4'b1111;
          end
          count_next = WAIT_INIT;
          state_next = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (count != 4'd0) begin
          count_next = count - 4'd1;
        end else begin
          if (grant_d) begin
            // A write completion returns zero on the read-data port.
            d_rdata_next = lat_we ? 32'd0 : mem_readdata;
            d_ack_next   = 1'b1;
          end else begin
            i_rdata_next = mem_readdata;
            i_ack_next   = 1'b1;
          end
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // RAM bus
  // --------------------------------------------------------------------------
  logic in_access;
  assign in_access = (state == ST_ACCESS);

  // Strobes are gated by reset directly so that a reset sampled during the
  // final write cycle cannot commit the write on that same edge.
  assign mem_read       = in_access && !lat_we && !reset;
  assign mem_write      = in_access &&  lat_we && (count == 4'd0) && !reset;
  assign mem_byteenable = in_access ? lat_byteen : 4'b0000;
  assign mem_address    = lat_addr;
  assign mem_writedata  = lat_wdata;

  assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               reference model (pending requests, tie-break rule, fixed
//               latency, byte-merged shadow memory) predicts every response.
//               A second instance with WAIT_CYCLES=0 covers the early-drop
//               and input-change-after-grant case.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int W = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance signals
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_byteen, mem_byteenable;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, busy;

  // zero-wait instance signals
  logic        z_i_req, z_i_ack, z_d_req, z_d_we, z_d_ack;
  logic [31:0] z_i_addr, z_i_rdata, z_d_addr, z_d_wdata, z_d_rdata;
  logic [3:0]  z_d_byteen, z_mem_byteenable;
  logic [31:0] z_mem_address, z_mem_writedata, z_mem_readdata;
  logic        z_mem_read, z_mem_write, z_busy;

  mem_port_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteen(d_byteen), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .busy(busy)
  );

  mem_port_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_byteen(z_d_byteen), .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .mem_address(z_mem_address), .mem_read(z_mem_read), .mem_write(z_mem_write),
    .mem_writedata(z_mem_writedata), .mem_byteenable(z_mem_byteenable),
    .mem_readdata(z_mem_readdata), .busy(z_busy)
  );

  // RAM driven by the DUT bus; model_mem is the bench's own expectation.
  logic [31:0] ram       [256];
  logic [31:0] model_mem [256];
  logic        ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int k = 0; k < 256; k++) ram[k] <= model_mem[k];
    end else if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata   = ram[mem_address[7:0]];
  assign z_mem_readdata = ram[z_mem_address[7:0]];

  int checks   = 0;
  int failures = 0;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // reference model: outstanding requests and grant history
  bit          pi, pd, m_last_d;
  logic [31:0] pi_addr, pd_addr, pd_wdata;
  logic        pd_we;
  logic [3:0]  pd_be;

  task automatic issue_i(input logic [31:0] a);
    pi = 1; pi_addr = a;
    i_req = 1'b1; i_addr = a;
  endtask

  task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
    pd = 1; pd_we = we; pd_addr = a; pd_wdata = wd; pd_be = be;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_byteen = be;
  endtask

  // Called in an IDLE cycle with at least one request pending. Runs one
  // transaction and returns in the following IDLE cycle.
  // scramble: winner changes its inputs / may drop req right after the grant.
  // hold    : winner keeps req high after its ack (becomes a new request).
  task automatic run_one(input bit scramble, input bit hold);
    bit          wd;
    logic [31:0] ea, ewd, exp_rd;
    logic        ewe;
    logic [3:0]  ebe;
    if (pi && pd) begin
`ifdef ARB_DATA_PRIORITY_EN
      wd = 1;
`else
      wd = !m_last_d;
`endif
    end else begin
      wd = pd;
    end
    m_last_d = wd;
    ea     = wd ? pd_addr : pi_addr;
    ewe    = wd ? pd_we : 1'b0;
    ebe    = wd ? pd_be : 4'hF;
    ewd    = pd_wdata;
    exp_rd = ewe ? 32'd0 : model_mem[ea[7:0]];

    for (int n = 1; n <= W + 2; n++) begin
      @(posedge clk); #1;
      if (n == 1 && scramble) begin
        if (wd) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; d_byteen = 4'($urandom);
          if ($urandom_range(0, 1) == 1) d_req = 1'b0;
        end else begin
          i_addr = $urandom;
          if ($urandom_range(0, 1) == 1) i_req = 1'b0;
        end
        #1;
      end
      if (n <= W + 1) begin
        chk1("busy_access", busy, 1'b1);
        chk32("mem_address", mem_address, ea);
        chk1("mem_read", mem_read, !ewe);
        chk1("mem_write", mem_write, ewe && (n == W + 1));
        if (!wd || ewe) chk32("mem_byteenable", 32'(mem_byteenable), 32'(ebe));
        if (ewe && n == W + 1) chk32("mem_writedata", mem_writedata, ewd);
        chk1("i_ack_early", i_ack, 1'b0);
        chk1("d_ack_early", d_ack, 1'b0);
      end else begin
        chk1("i_ack", i_ack, !wd);
        chk1("d_ack", d_ack, wd);
        chk1("mem_read_resp", mem_read, 1'b0);
        chk1("mem_write_resp", mem_write, 1'b0);
        chk32("mem_byteenable_resp", 32'(mem_byteenable), 32'd0);
        if (wd) chk32("d_rdata", d_rdata, exp_rd);
        else    chk32("i_rdata", i_rdata, exp_rd);
        if (ewe) model_mem[ea[7:0]] = merge(model_mem[ea[7:0]], ewd, ebe);
        if (!hold) begin
          if (wd) begin pd = 0; d_req = 1'b0; end
          else    begin pi = 0; i_req = 1'b0; end
        end
      end
    end
    @(posedge clk); #1;
    chk1("busy_idle", busy, 1'b0);
    chk1("i_ack_idle", i_ack, 1'b0);
    chk1("d_ack_idle", d_ack, 1'b0);
  endtask

  task automatic drop_all();
    i_req = 1'b0; d_req = 1'b0; z_d_req = 1'b0; z_i_req = 1'b0;
    pi = 0; pd = 0; m_last_d = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ram_load = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_byteen = 0;
    z_i_req = 0; z_i_addr = 0; z_d_req = 0; z_d_we = 0; z_d_addr = 0; z_d_wdata = 0;
    z_d_byteen = 0;
    drop_all();
    for (int k = 0; k < 256; k++) model_mem[k] = $urandom;
    model_mem[16] = 32'hDEADBEEF;
    ram_load = 1'b1;
    @(posedge clk); #1;
    ram_load = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk32("rst_i_rdata", i_rdata, 32'd0);
    chk32("rst_d_rdata", d_rdata, 32'd0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_mem_byteenable", 32'(mem_byteenable), 32'd0);
    chk32("rst_mem_address", mem_address, 32'd0);
    chk1("rst_z_busy", z_busy, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // zero-wait instance: requester drops req and changes addr after grant
    z_d_req = 1'b1; z_d_we = 1'b0; z_d_addr = 32'h10; z_d_byteen = 4'hF;
    @(posedge clk); #1;
    z_d_req = 1'b0; z_d_addr = 32'h11; #1;
    chk32("z_mem_address_held", z_mem_address, 32'h10);
    chk1("z_mem_read", z_mem_read, 1'b1);
    chk1("z_d_ack_early", z_d_ack, 1'b0);
    @(posedge clk); #1;
    chk1("z_d_ack", z_d_ack, 1'b1);
    chk32("z_d_rdata", z_d_rdata, model_mem[16]);
    chk1("z_mem_write", z_mem_write, 1'b0);
    @(posedge clk); #1;
    chk1("z_d_ack_after", z_d_ack, 1'b0);
    chk1("z_i_ack", z_i_ack, 1'b0);
    chk1("z_busy_after", z_busy, 1'b0);

    // instruction fetch of 0x10
    issue_i(32'h10);
    run_one(0, 0);

    // partial write then read-back
    issue_d(1'b1, 32'h20, 32'h12345678, 4'b0011);
    run_one(0, 0);
    issue_d(1'b0, 32'h20, 32'h0, 4'hF);
    run_one(0, 0);
    chk32("d_rdata_low_half", {16'h0, d_rdata[15:0]}, 32'h5678);

    // both requesters held continuously
    issue_i(32'h40);
    issue_d(1'b0, 32'h41, 32'h0, 4'hF);
    repeat (4) run_one(0, 1);
    repeat (2) if (pi || pd) run_one(0, 0);

    // reset during the final write ACCESS cycle
    issue_d(1'b1, 32'h30, 32'hA5A5F00F, 4'hF);
    for (int n = 1; n <= W; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    chk1("pre_reset_mem_write", mem_write, 1'b1);
    reset = 1'b1;
    drop_all();
    #1;
    chk1("reset_gates_mem_write", mem_write, 1'b0);
    chk1("reset_gates_mem_read", mem_read, 1'b0);
    @(posedge clk); #1;
    chk1("abort_d_ack", d_ack, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_mem_write", mem_write, 1'b0);
    chk32("abort_mem_address", mem_address, 32'd0);
    chk32("abort_mem_byteenable", 32'(mem_byteenable), 32'd0);
    chk32("abort_d_rdata", d_rdata, 32'd0);
    chk32("abort_i_rdata", i_rdata, 32'd0);
    chk32("abort_ram_unchanged", ram[8'h30], model_mem[8'h30]);
    reset = 1'b0;
    @(posedge clk); #1;
    chk1("abort_no_late_ack", d_ack, 1'b0);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      bit sc, hd;
      if (!pi && $urandom_range(0, 1) == 1) issue_i(32'($urandom_range(0, 63)));
      if (!pd && $urandom_range(0, 1) == 1)
        issue_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                4'($urandom));
      if (!pi && !pd) begin
        @(posedge clk); #1;
        chk1("busy_noreq", busy, 1'b0);
      end else begin
        sc = ($urandom_range(0, 3) == 0);
        hd = !sc && ($urandom_range(0, 3) == 0);
        run_one(sc, hd);
      end
    end
    repeat (2) if (pi || pd) run_one(0, 0);

    // final read-back of a few locations through the arbiter
    for (int k = 0; k < 4; k++) begin
      issue_d(1'b0, 32'(k * 7), 32'h0, 4'hF);
      run_one(0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra ACCESS cycles before the memory result is sampled (legal 0..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_req  input  1  instruction-fetch request, held until i_ack.
REQ-005 SHALL have port i_addr  input  32  instruction word address.
REQ-006 SHALL have port i_ack  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port i_rdata  output  32  fetched word, valid while i_ack=1.
REQ-008 SHALL have port d_req  input  1  data request, held until d_ack.
REQ-009 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port d_addr  input  32  data word address.
REQ-011 SHALL have port d_wdata  input  32  write data.
REQ-012 SHALL have port d_byteen  input  4  write byte enables.
REQ-013 SHALL have port d_ack  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port d_rdata  output  32  read word, valid while d_ack=1.
REQ-015 SHALL have ports mem_address (32), mem_read (1), mem_write (1), mem_writedata (32), mem_byteenable (4), all outputs to the shared word-addressed RAM.
REQ-016 SHALL have port mem_readdata  input  32  combinational RAM read data.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP.
- IDLE: no request -> stay in IDLE. Any request -> pick a winner, latch its addr/we/wdata/byteen, load wait counter with WAIT_CYCLES, go to ACCESS.
- ACCESS: counter != 0 -> decrement. Counter == 0 -> register mem_readdata into the winner's rdata, go to RESP.
- RESP: pulse the winner's ack, go to IDLE.
REQ-019 SHALL drive the mem_* bus only from latched values; requester inputs changing after the grant have no effect on the bus.
REQ-020 SHALL hold mem_read high for every ACCESS cycle of a read.
REQ-021 SHALL assert mem_write only in the final ACCESS cycle (counter == 0), giving exactly one write edge per write transaction.
REQ-022 SHALL drive mem_byteenable = 4'b1111 and mem_write = 0 for instruction transactions.
REQ-023 SHALL drive mem_read = mem_write = 0 and mem_byteenable = 0 outside ACCESS.
REQ-024 SHALL give latency from request sampled in IDLE (cycle 0) to ack at cycle WAIT_CYCLES+2, and one transaction per WAIT_CYCLES+3 cycles.
REQ-025 SHALL treat a req still high in the cycle after its ack as a new request.
REQ-026 SHALL, on a tie, grant the requester that did not win the previous grant (round-robin via a last_grant flag).
REQ-027 SHALL complete an in-flight transaction and pulse ack even if the winner drops req early.
REQ-028 SHALL hold rdata outputs between acks; rdata is undefined-by-contract outside ack and 0 after a write ack.

Reset
REQ-029 SHALL, on reset, set state = IDLE, counter = 0, i_ack = d_ack = 0, i_rdata = d_rdata = 0, all latched fields = 0, and last_grant = D (instruction wins the first tie).
REQ-030 SHALL gate mem_read and mem_write with !reset so that no write commits on the edge where a reset mid-ACCESS is sampled; the aborted transaction is never acked.

Configuration
REQ-031 SHALL use macro ARB_DATA_PRIORITY_EN.
- Defined: d_req always wins ties; last_grant is ignored.
- Undefined: round-robin per REQ-026.

Verification
REQ-032 Reset, then i_req=1 with i_addr=0x10 where RAM[0x10]=0xDEADBEEF, WAIT_CYCLES=1 -> i_ack at cycle 3, i_rdata=0xDEADBEEF, mem_read high for cycles 1-2.
REQ-033 Data write d_addr=0x20, d_wdata=0x12345678, d_byteen=4'b0011 -> mem_write high for exactly one cycle; a later read of 0x20 returns the low half updated.
REQ-034 i_req and d_req held continuously -> grants alternate I, D, I, D; with ARB_DATA_PRIORITY_EN defined, only D is granted while d_req stays high.
REQ-035 Reset asserted during the final write ACCESS cycle -> memory unchanged, no ack, all outputs 0 on the next cycle.
REQ-036 WAIT_CYCLES=0, d_req dropped in cycle 1 of a read -> d_ack still pulses at cycle 2; d_addr changed in cycle 1 -> mem_address keeps the original value.
